// File: rtl/sp_ram_gen.sv
// sp_ram_gen: parametrised single-port synchronous RAM with byte-lane write
// enables, optional output register, selectable write-cycle read behaviour
// and a sequential clear engine that sweeps the array to CLRVAL.
//
// Ports:
//   CLK    clock, rising edge
//   RSTN   synchronous active-low reset (control, output and pipeline regs)
//   CE     clock enable for user accesses
//   WE     1 = write, 0 = read
//   CS     chip select, block responds when CS == CSDECODE
//   AD     word address; AD >= DEPTH is out of range
//   DI     write data
//   BE     byte-lane write enables, lane i = DI[i*BYTE_WIDTH +: BYTE_WIDTH]
//   CLR    request a clear sweep (sampled only while idle)
//   DO     read data
//   DOVAL  one-cycle pulse in the cycle DO takes new data
//   BUSY   high while a clear sweep is in progress
module sp_ram_gen #(
  parameter int                    DATA_WIDTH = 18,
  parameter int                    BYTE_WIDTH = 9,
  parameter int                    DEPTH      = 512,
  parameter int                    ADDR_WIDTH = 9,
  parameter string                 REGMODE    = "NOREG",
  parameter string                 WRITEMODE  = "NORMAL",
  parameter logic [2:0]            CSDECODE   = 3'b000,
  parameter logic [DATA_WIDTH-1:0] CLRVAL     = '0,
  parameter bit                    INIT_CLEAR = 1'b0,
  localparam int                   NBE        = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CE,
  input  logic                  WE,
  input  logic [2:0]            CS,
  input  logic [ADDR_WIDTH-1:0] AD,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic [NBE-1:0]        BE,
  input  logic                  CLR,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  DOVAL,
  output logic                  BUSY
);

  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
  localparam bit                  OUT_REG  = (REGMODE == "OUTREG");
  localparam bit                  WR_THRU  = (WRITEMODE == "WRITETHROUGH");
  localparam bit                  RD_B4_WR = (WRITEMODE == "READBEFOREWRITE");

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  generate
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("sp_ram_gen: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((64'(1) << ADDR_WIDTH) < 64'(DEPTH)) begin : g_bad_addr
      $error("sp_ram_gen: ADDR_WIDTH too small for DEPTH");
    end
    if (!(REGMODE == "NOREG" || REGMODE == "OUTREG")) begin : g_bad_regmode
      $error("sp_ram_gen: REGMODE must be NOREG or OUTREG");
    end
    if (!(WRITEMODE == "NORMAL" || WR_THRU || RD_B4_WR)) begin : g_bad_wrmode
      $error("sp_ram_gen: unsupported WRITEMODE");
    end
  endgenerate

  // Replace the lanes selected by lane_en, keep the others.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NBE-1:0]        lane_en
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NBE; i++) begin
      if (lane_en[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state;
  logic [IDX_W-1:0]      cnt;
  logic                  init_pend;
  logic                  sel;
  logic                  in_range;
  logic                  wr_en;
  logic                  out_vld;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign BUSY     = (state == CLEAR);
  assign sel      = CE & (CS == CSDECODE) & ~BUSY;
  assign in_range = ({1'b0, AD} < DEPTH_C);
  // Only meaningful when in_range, where AD fits in IDX_W bits.
  assign idx      = AD[IDX_W-1:0];

  always_comb begin
    cur_word = '0;
    if (in_range) cur_word = mem[idx];
    merged_word = lane_merge(cur_word, DI, BE);
    wr_en       = sel & WE & in_range;
    // Out-of-range accesses always present zero on the read path.
    rd_word = '0;
    if (in_range) rd_word = (WE && WR_THRU) ? merged_word : cur_word;
    out_vld = sel & (~WE | WR_THRU | RD_B4_WR);
  end

  // Array write port: the sweep owns the port while BUSY, user writes
  // are already blocked by sel in that case.
  always_ff @(posedge CLK) begin
    if (BUSY && RSTN) begin
      mem[cnt] <= CLRVAL;
    end else if (wr_en) begin
      mem[idx] <= merged_word;
    end
  end

  // Clear engine. init_pend carries INIT_CLEAR across reset so the sweep
  // launches on the first edge after release.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      init_pend <= INIT_CLEAR;
    end else begin
      case (state)
        IDLE: begin
          init_pend <= 1'b0;
          if (CLR || init_pend) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          if (cnt == LAST_IDX) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
      endcase
    end
  end

  generate
    if (OUT_REG) begin : g_outreg
      logic [DATA_WIDTH-1:0] data_p1;
      logic                  vld_p1;

      always_ff @(posedge CLK) begin
        if (!RSTN) begin
          data_p1 <= '0;
          vld_p1  <= 1'b0;
          DO      <= '0;
          DOVAL   <= 1'b0;
        end else begin
          // stage p1: capture array output
          vld_p1 <= out_vld;
          if (out_vld) data_p1 <= rd_word;
          // stage p2: output register
          DOVAL <= vld_p1;
          if (vld_p1) DO <= data_p1;
        end
      end
    end else begin : g_noreg
      always_ff @(posedge CLK) begin
        if (!RSTN) begin
          DO    <= '0;
          DOVAL <= 1'b0;
        end else begin
          // stage p1: array output drives DO directly
          DOVAL <= out_vld;
          if (out_vld) DO <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_gen.sv
// Bench for sp_ram_gen: three instances on shared stimulus
//   u_nr : NOREG,  NORMAL
//   u_wt : OUTREG, WRITETHROUGH
//   u_rb : NOREG,  READBEFOREWRITE, INIT_CLEAR=1
// all with DEPTH=300 and CLRVAL=0x15555.
module tb_sp_ram_gen;
  localparam int              DW   = 18;
  localparam int              AW   = 9;
  localparam int              NB   = 2;
  localparam int              DEP  = 300;
  localparam logic [DW-1:0]   CLRV = 18'h15555;
  localparam int              NV   = 19;

  logic          CLK  = 1'b0;
  logic          RSTN = 1'b0;
  logic          CE   = 1'b0;
  logic          WE   = 1'b0;
  logic          CLR  = 1'b0;
  logic [2:0]    CS   = 3'b000;
  logic [AW-1:0] AD   = '0;
  logic [DW-1:0] DI   = '0;
  logic [NB-1:0] BE   = '0;

  logic [DW-1:0] do_nr, do_wt, do_rb;
  logic          doval_nr, doval_wt, doval_rb;
  logic          busy_nr, busy_wt, busy_rb;

  always #5 CLK = ~CLK;

  sp_ram_gen #(.DATA_WIDTH(DW), .BYTE_WIDTH(9), .DEPTH(DEP), .ADDR_WIDTH(AW),
               .REGMODE("NOREG"), .WRITEMODE("NORMAL"), .CSDECODE(3'b000),
               .CLRVAL(CLRV), .INIT_CLEAR(1'b0)) u_nr (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .WE(WE), .CS(CS), .AD(AD), .DI(DI), .BE(BE),
    .CLR(CLR), .DO(do_nr), .DOVAL(doval_nr), .BUSY(busy_nr));

  sp_ram_gen #(.DATA_WIDTH(DW), .BYTE_WIDTH(9), .DEPTH(DEP), .ADDR_WIDTH(AW),
               .REGMODE("OUTREG"), .WRITEMODE("WRITETHROUGH"), .CSDECODE(3'b000),
               .CLRVAL(CLRV), .INIT_CLEAR(1'b0)) u_wt (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .WE(WE), .CS(CS), .AD(AD), .DI(DI), .BE(BE),
    .CLR(CLR), .DO(do_wt), .DOVAL(doval_wt), .BUSY(busy_wt));

  sp_ram_gen #(.DATA_WIDTH(DW), .BYTE_WIDTH(9), .DEPTH(DEP), .ADDR_WIDTH(AW),
               .REGMODE("NOREG"), .WRITEMODE("READBEFOREWRITE"), .CSDECODE(3'b000),
               .CLRVAL(CLRV), .INIT_CLEAR(1'b1)) u_rb (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .WE(WE), .CS(CS), .AD(AD), .DI(DI), .BE(BE),
    .CLR(CLR), .DO(do_rb), .DOVAL(doval_rb), .BUSY(busy_rb));

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] ad;
    logic [DW-1:0] di;
    logic [NB-1:0] be;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t          q_nr[$];
  exp_t          q_wt[$];
  exp_t          q_rb[$];
  vec_t          vecs[NV];
  logic [DW-1:0] mdl[DEP];
  logic [DW-1:0] prev_do[3];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  bit            rst_edge = 1'b0;
  bit            mon_en   = 1'b0;
  int            n, n_wt, n_rb;

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    rst_edge <= !RSTN;
  end

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] o,
                                               input logic [DW-1:0] d,
                                               input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    if (be[0]) r[8:0]  = d[8:0];
    if (be[1]) r[17:9] = d[17:9];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Expected DO arrival: one edge after sampling for NOREG, two for OUTREG.
  task automatic push(input int id, input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    case (id)
      0: begin e.cyc = cyc + 1; q_nr.push_back(e); end
      1: begin e.cyc = cyc + 2; q_wt.push_back(e); end
      default: begin e.cyc = cyc + 1; q_rb.push_back(e); end
    endcase
  endtask

  task automatic check_port(input int id, input logic v, input logic [DW-1:0] d);
    exp_t  e;
    bit    have;
    string nm;
    nm   = (id == 0) ? "nr" : (id == 1) ? "wt" : "rb";
    have = 1'b0;
    if (v === 1'b1) begin
      case (id)
        0: if (q_nr.size() > 0) begin e = q_nr.pop_front(); have = 1'b1; end
        1: if (q_wt.size() > 0) begin e = q_wt.pop_front(); have = 1'b1; end
        default: if (q_rb.size() > 0) begin e = q_rb.pop_front(); have = 1'b1; end
      endcase
      checks++;
      if (!have) begin
        failures++;
        $display("FAIL dout_%s: unexpected DOVAL with DO=0x%0h at cycle %0d", nm, d, cyc);
      end else if (e.data !== d || e.cyc != cyc) begin
        failures++;
        $display("FAIL dout_%s: got 0x%0h at cycle %0d, want 0x%0h at cycle %0d",
                 nm, d, cyc, e.data, e.cyc);
      end
    end else if (!rst_edge) begin
      checks++;
      if (d !== prev_do[id]) begin
        failures++;
        $display("FAIL hold_%s: DO changed to 0x%0h without DOVAL, want 0x%0h", nm, d, prev_do[id]);
      end
    end
    prev_do[id] = d;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      check_port(0, doval_nr, do_nr);
      check_port(1, doval_wt, do_wt);
      check_port(2, doval_rb, do_rb);
    end
  end

  // One access cycle; write expectations come from the bench's own array model.
  task automatic do_access(input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] di,
                           input logic [NB-1:0] be, input logic [DW-1:0] exp_a,
                           input logic [DW-1:0] exp_b);
    logic [DW-1:0] old_w, new_w;
    bit            inr;
    inr   = (int'(ad) < DEP);
    old_w = inr ? mdl[ad] : '0;
    new_w = inr ? lane_merge(old_w, di, be) : '0;
    CE = 1'b1; CS = 3'b000; WE = we; AD = ad; DI = di; BE = be;
    if (we) begin
      push(1, new_w);
      push(2, old_w);
      if (inr) mdl[ad] = new_w;
    end else begin
      push(0, exp_a);
      push(1, exp_a);
      push(2, exp_b);
    end
    @(negedge CLK);
    CE = 1'b0; WE = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 9'd5,   18'h2AB55, 2'b11, 18'h00000};
    vecs[1]  = '{1'b0, 9'd5,   18'h00000, 2'b00, 18'h2AB55};
    vecs[2]  = '{1'b1, 9'd7,   18'h3FFFF, 2'b11, 18'h00000};
    vecs[3]  = '{1'b1, 9'd7,   18'h00000, 2'b01, 18'h00000};
    vecs[4]  = '{1'b0, 9'd7,   18'h00000, 2'b00, 18'h3FE00};
    vecs[5]  = '{1'b1, 9'd3,   18'h00011, 2'b11, 18'h00000};
    vecs[6]  = '{1'b1, 9'd3,   18'h00022, 2'b11, 18'h00000};
    vecs[7]  = '{1'b0, 9'd3,   18'h00000, 2'b00, 18'h00022};
    vecs[8]  = '{1'b0, 9'd0,   18'h00000, 2'b00, 18'h15555};
    vecs[9]  = '{1'b0, 9'd10,  18'h00000, 2'b00, 18'h15555};
    vecs[10] = '{1'b0, 9'd299, 18'h00000, 2'b00, 18'h15555};
    vecs[11] = '{1'b0, 9'd300, 18'h00000, 2'b00, 18'h00000};
    vecs[12] = '{1'b0, 9'd511, 18'h00000, 2'b00, 18'h00000};
    vecs[13] = '{1'b1, 9'd300, 18'h3FFFF, 2'b11, 18'h00000};
    vecs[14] = '{1'b0, 9'd300, 18'h00000, 2'b00, 18'h00000};
    vecs[15] = '{1'b1, 9'd9,   18'h12345, 2'b00, 18'h00000};
    vecs[16] = '{1'b0, 9'd9,   18'h00000, 2'b00, 18'h15555};
    vecs[17] = '{1'b1, 9'd9,   18'h0ABCD, 2'b10, 18'h00000};
    vecs[18] = '{1'b0, 9'd9,   18'h00000, 2'b00, 18'h0AB55};

    // Reset state
    RSTN = 1'b0;
    @(negedge CLK);
    mon_en = 1'b1;
    @(negedge CLK);
    chk("rst_busy_nr",  32'(busy_nr),  32'd0);
    chk("rst_busy_wt",  32'(busy_wt),  32'd0);
    chk("rst_busy_rb",  32'(busy_rb),  32'd0);
    chk("rst_doval_nr", 32'(doval_nr), 32'd0);
    chk("rst_doval_wt", 32'(doval_wt), 32'd0);
    chk("rst_doval_rb", 32'(doval_rb), 32'd0);
    chk("rst_do_nr",    32'(do_nr),    32'd0);
    chk("rst_do_wt",    32'(do_wt),    32'd0);
    chk("rst_do_rb",    32'(do_rb),    32'd0);

    // INIT_CLEAR sweep after release
    RSTN = 1'b1;
    @(negedge CLK);
    chk("init_busy_rb", 32'(busy_rb), 32'd1);
    chk("init_busy_nr", 32'(busy_nr), 32'd0);
    n = 0;
    while (busy_rb === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
    chk("init_len_rb", n, DEP);

    // CLR sweep; a write and a second CLR land mid-sweep
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("clr_busy_nr", 32'(busy_nr), 32'd1);
    n = 0; n_wt = 0; n_rb = 0;
    while (busy_nr === 1'b1 && n < 1000) begin
      n++;
      if (busy_wt === 1'b1) n_wt++;
      if (busy_rb === 1'b1) n_rb++;
      if (n == 200) begin
        CE = 1'b1; WE = 1'b1; AD = 9'd10; DI = 18'h3FFFF; BE = 2'b11; CLR = 1'b1;
      end else begin
        CE = 1'b0; WE = 1'b0; CLR = 1'b0;
      end
      @(negedge CLK);
    end
    CE = 1'b0; WE = 1'b0; CLR = 1'b0;
    chk("clr_len_nr", n, DEP);
    chk("clr_len_wt", n_wt, DEP);
    chk("clr_len_rb", n_rb, DEP);
    for (int i = 0; i < DEP; i++) mdl[i] = CLRV;

    // Table of accesses, issued back to back
    for (int i = 0; i < NV; i++) begin
      do_access(vecs[i].we, vecs[i].ad, vecs[i].di, vecs[i].be, vecs[i].exp, vecs[i].exp);
    end
    repeat (3) @(negedge CLK);

    // CS / CE gating
    CS = 3'b001; CE = 1'b1; WE = 1'b1; AD = 9'd2; DI = 18'h00001; BE = 2'b11;
    @(negedge CLK);
    CS = 3'b000; CE = 1'b0; WE = 1'b0; AD = 9'd5;
    @(negedge CLK);
    repeat (2) @(negedge CLK);
    do_access(1'b0, 9'd2, 18'h0, 2'b00, CLRV, CLRV);

    // Reset in the middle of a sweep
    do_access(1'b1, 9'd200, 18'h00C3C, 2'b11, 18'h0, 18'h0);
    do_access(1'b1, 9'd50,  18'h00A5A, 2'b11, 18'h0, 18'h0);
    CLR = 1'b1;
    do_access(1'b0, 9'd5, 18'h0, 2'b00, 18'h2AB55, 18'h2AB55);
    CLR = 1'b0;
    n = 0;
    while (busy_nr === 1'b1 && n < 1000) begin
      n++;
      if (n == 100) RSTN = 1'b0;
      @(negedge CLK);
    end
    chk("abort_len_nr",   n, 32'd100);
    chk("abort_busy_nr",  32'(busy_nr),  32'd0);
    chk("abort_busy_wt",  32'(busy_wt),  32'd0);
    chk("abort_busy_rb",  32'(busy_rb),  32'd0);
    chk("abort_do_nr",    32'(do_nr),    32'd0);
    chk("abort_do_wt",    32'(do_wt),    32'd0);
    chk("abort_do_rb",    32'(do_rb),    32'd0);
    chk("abort_doval_wt", 32'(doval_wt), 32'd0);
    RSTN = 1'b1;
    @(negedge CLK);
    chk("reinit_busy_rb", 32'(busy_rb), 32'd1);
    chk("reinit_busy_nr", 32'(busy_nr), 32'd0);
    n = 0;
    while (busy_rb === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
    chk("reinit_len_rb", n, DEP);
    do_access(1'b0, 9'd50,  18'h0, 2'b00, CLRV,      CLRV);
    do_access(1'b0, 9'd200, 18'h0, 2'b00, 18'h00C3C, CLRV);
    repeat (4) @(negedge CLK);

    chk("drain_nr", q_nr.size(), 32'd0);
    chk("drain_wt", q_wt.size(), 32'd0);
    chk("drain_rb", q_rb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
